demux_dispatch_ctrl: RTL and testbench

Scheduler in front of the three decryption channels. It accepts 32-bit master words with a channel select through a valid/ready handshake. Each word is serialised MSB-first into 8-bit bytes, one byte per cycle, and steered to the selected channel, honouring a per-channel busy backpressure. It replaces free-running byte counting with an explicit FSM, so select changes only take effect on word boundaries.

---
 rtl/demux_dispatch_pkg.sv | 13 +
 rtl/demux_dispatch_ctrl_if.sv | 48 ++++
 rtl/demux_byte_slicer.sv | 35 +++
 rtl/demux_dispatch_ctrl.sv | 146 ++++++++++++++
 tb/tb_demux_dispatch_ctrl.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/demux_dispatch_pkg.sv
// Shared types and constants for the demux dispatch scheduler.
package demux_dispatch_pkg;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  localparam int unsigned CH_COUNT    = 3;
  localparam logic [1:0]  SEL_INVALID = 2'd3;
  localparam int unsigned STAT_W      = 16;

endpackage

// File: rtl/demux_dispatch_ctrl_if.sv
// Word-side handshake and per-channel byte outputs of demux_dispatch_ctrl.
// Optional statistics signals exist only with DEMUX_DISPATCH_STATS_EN defined.
interface demux_dispatch_ctrl_if
  import demux_dispatch_pkg::*;
#(
  parameter int unsigned MST_DWIDTH = 32,
  parameter int unsigned SYS_DWIDTH = 8
);

  logic [1:0]            select;
  logic [MST_DWIDTH-1:0] data_i;
  logic                  valid_i;
  logic                  ready_o;
  logic [CH_COUNT-1:0]   ch_busy_i;
  logic [SYS_DWIDTH-1:0] data0_o;
  logic [SYS_DWIDTH-1:0] data1_o;
  logic [SYS_DWIDTH-1:0] data2_o;
  logic                  valid0_o;
  logic                  valid1_o;
  logic                  valid2_o;
  logic                  err_sel_o;
  logic                  idle_o;
`ifdef DEMUX_DISPATCH_STATS_EN
  logic [STAT_W-1:0]     word_cnt0_o;
  logic [STAT_W-1:0]     word_cnt1_o;
  logic [STAT_W-1:0]     word_cnt2_o;
  logic [STAT_W-1:0]     drop_cnt_o;
`endif

  modport master (
    output select, data_i, valid_i, ch_busy_i,
    input  ready_o, data0_o, data1_o, data2_o, valid0_o, valid1_o, valid2_o,
           err_sel_o, idle_o
`ifdef DEMUX_DISPATCH_STATS_EN
  , input  word_cnt0_o, word_cnt1_o, word_cnt2_o, drop_cnt_o
`endif
  );

  modport slave (
    input  select, data_i, valid_i, ch_busy_i,
    output ready_o, data0_o, data1_o, data2_o, valid0_o, valid1_o, valid2_o,
           err_sel_o, idle_o
`ifdef DEMUX_DISPATCH_STATS_EN
  , output word_cnt0_o, word_cnt1_o, word_cnt2_o, drop_cnt_o
`endif
  );

endinterface

// File: rtl/demux_byte_slicer.sv
// Holds the word in flight and selects its byte_cnt-th byte, MSB first.
module demux_byte_slicer #(
  parameter  int unsigned MST_DWIDTH = 32,
  parameter  int unsigned SYS_DWIDTH = 8,
  localparam int unsigned BYTES      = MST_DWIDTH / SYS_DWIDTH,
  localparam int unsigned CNT_W      = (BYTES > 1) ? $clog2(BYTES) : 1
) (
  input  logic                  clk_sys,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [MST_DWIDTH-1:0] word_in,
  input  logic [CNT_W-1:0]      idx,
  output logic [SYS_DWIDTH-1:0] byte_out
);

  logic [MST_DWIDTH-1:0] word_q;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
    end else if (load) begin
      word_q <= word_in;
    end
  end

  always_comb begin
    byte_out = '0;
    for (int unsigned i = 0; i < BYTES; i++) begin
      if (idx == CNT_W'(i)) begin
        byte_out = word_q[MST_DWIDTH-1-SYS_DWIDTH*i -: SYS_DWIDTH];
      end
    end
  end

endmodule

// File: rtl/demux_dispatch_ctrl.sv
// Word-to-byte scheduler feeding three decryption channels with busy backpressure.
// Define DEMUX_DISPATCH_STATS_EN to add saturating per-channel word and drop counters.
module demux_dispatch_ctrl
  import demux_dispatch_pkg::*;
#(
  parameter int unsigned MST_DWIDTH = 32,
  parameter int unsigned SYS_DWIDTH = 8
) (
  input  logic                 clk_sys,
  input  logic                 rst_n,
  demux_dispatch_ctrl_if.slave bus
);

  localparam int unsigned BYTES = MST_DWIDTH / SYS_DWIDTH;
  localparam int unsigned CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BYTES - 1);

  state_t                state_q, state_d;
  logic [1:0]            sel_q, sel_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  load;
  logic                  ready;
  logic                  busy_sel;
  logic                  issue;
  logic                  last_issue;
  logic                  xfer;
  logic [SYS_DWIDTH-1:0] cur_byte;
  logic [CH_COUNT-1:0]   valid_d, valid_q;
  logic                  err_d, err_q;
  logic [SYS_DWIDTH-1:0] data_q [CH_COUNT];

  demux_byte_slicer #(
    .MST_DWIDTH(MST_DWIDTH),
    .SYS_DWIDTH(SYS_DWIDTH)
  ) u_slicer (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .load    (load),
    .word_in (bus.data_i),
    .idx     (cnt_q),
    .byte_out(cur_byte)
  );

  // Only the busy bit of the channel owning the word in flight matters.
  always_comb begin
    busy_sel = 1'b0;
    for (int unsigned n = 0; n < CH_COUNT; n++) begin
      if (sel_q == 2'(n)) busy_sel = bus.ch_busy_i[n];
    end
  end

  assign issue      = (state_q == SEND) && !busy_sel;
  assign last_issue = issue && (cnt_q == LAST_IDX);
  assign ready      = (state_q == IDLE) || last_issue;
  assign xfer       = bus.valid_i && ready;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    valid_d = '0;
    err_d   = 1'b0;

    if (issue) begin
      for (int unsigned n = 0; n < CH_COUNT; n++) begin
        if (sel_q == 2'(n)) valid_d[n] = 1'b1;
      end
      cnt_d = cnt_q + CNT_W'(1);
      if (last_issue) state_d = IDLE;
    end

    // A transfer in the last-byte cycle overrides the return to IDLE.
    if (xfer) begin
      if (bus.select == SEL_INVALID) begin
        err_d = 1'b1;
      end else begin
        load    = 1'b1;
        sel_d   = bus.select;
        cnt_d   = '0;
        state_d = SEND;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      err_q   <= 1'b0;
      for (int unsigned n = 0; n < CH_COUNT; n++) data_q[n] <= '0;
    end else begin
      valid_q <= valid_d;
      err_q   <= err_d;
      for (int unsigned n = 0; n < CH_COUNT; n++) begin
        data_q[n] <= valid_d[n] ? cur_byte : '0;
      end
    end
  end

  assign bus.ready_o   = ready;
  assign bus.data0_o   = data_q[0];
  assign bus.data1_o   = data_q[1];
  assign bus.data2_o   = data_q[2];
  assign bus.valid0_o  = valid_q[0];
  assign bus.valid1_o  = valid_q[1];
  assign bus.valid2_o  = valid_q[2];
  assign bus.err_sel_o = err_q;
  assign bus.idle_o    = (state_q == IDLE) && (valid_q == '0);

`ifdef DEMUX_DISPATCH_STATS_EN
  logic [STAT_W-1:0] word_cnt_q [CH_COUNT];
  logic [STAT_W-1:0] drop_cnt_q;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
      for (int unsigned n = 0; n < CH_COUNT; n++) word_cnt_q[n] <= '0;
    end else begin
      if (err_d && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + STAT_W'(1);
      for (int unsigned n = 0; n < CH_COUNT; n++) begin
        if (last_issue && (sel_q == 2'(n)) && (word_cnt_q[n] != '1)) begin
          word_cnt_q[n] <= word_cnt_q[n] + STAT_W'(1);
        end
      end
    end
  end

  assign bus.word_cnt0_o = word_cnt_q[0];
  assign bus.word_cnt1_o = word_cnt_q[1];
  assign bus.word_cnt2_o = word_cnt_q[2];
  assign bus.drop_cnt_o  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Directed bench for demux_dispatch_ctrl with a byte-queue reference model checked every cycle.
module tb_demux_dispatch_ctrl;

  logic clk_sys = 1'b0;
  logic rst_n   = 1'b0;

  always #5 clk_sys = ~clk_sys;

  demux_dispatch_ctrl_if #(.MST_DWIDTH(32), .SYS_DWIDTH(8)) bus ();

  demux_dispatch_ctrl #(.MST_DWIDTH(32), .SYS_DWIDTH(8)) dut (
    .clk_sys(clk_sys),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: bytes still owed for the word in flight, and the registered outputs expected now.
  logic [7:0] mq [$];
  int         mch = 0;
  logic [2:0] exp_v = '0;
  logic [7:0] exp_d [3] = '{default: 8'h00};
  logic       exp_err = 1'b0;
  int         m_wcnt [3] = '{default: 0};
  int         m_drop = 0;

  logic [2:0] o_v;
  logic [7:0] o_d [3];
  logic       o_rdy, o_err, o_idle;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exp_v   = '0;
    exp_d   = '{default: 8'h00};
    exp_err = 1'b0;
    m_wcnt  = '{default: 0};
    m_drop  = 0;
  endtask

  task automatic tick();
    logic       m_ready;
    logic [2:0] nv;
    logic [7:0] nd [3];
    logic       nerr;
    logic [31:0] w;
    @(negedge clk_sys);
    o_v    = {bus.valid2_o, bus.valid1_o, bus.valid0_o};
    o_d[0] = bus.data0_o;
    o_d[1] = bus.data1_o;
    o_d[2] = bus.data2_o;
    o_rdy  = bus.ready_o;
    o_err  = bus.err_sel_o;
    o_idle = bus.idle_o;
    chk("valid", 32'(o_v), 32'(exp_v));
    chk("data0", 32'(o_d[0]), 32'(exp_d[0]));
    chk("data1", 32'(o_d[1]), 32'(exp_d[1]));
    chk("data2", 32'(o_d[2]), 32'(exp_d[2]));
    chk("err_sel", 32'(o_err), 32'(exp_err));
    chk("idle", 32'(o_idle), 32'((mq.size() == 0) && (exp_v == 3'b000)));
`ifdef DEMUX_DISPATCH_STATS_EN
    chk("word_cnt0", 32'(bus.word_cnt0_o), 32'(m_wcnt[0]));
    chk("word_cnt1", 32'(bus.word_cnt1_o), 32'(m_wcnt[1]));
    chk("word_cnt2", 32'(bus.word_cnt2_o), 32'(m_wcnt[2]));
    chk("drop_cnt", 32'(bus.drop_cnt_o), 32'(m_drop));
`endif
    m_ready = (mq.size() == 0) || ((mq.size() == 1) && !bus.ch_busy_i[mch]);
    chk("ready", 32'(o_rdy), 32'(m_ready));
    nv   = '0;
    nd   = '{default: 8'h00};
    nerr = 1'b0;
    if (rst_n) begin
      if ((mq.size() > 0) && !bus.ch_busy_i[mch]) begin
        nv[mch] = 1'b1;
        nd[mch] = mq.pop_front();
        if (mq.size() == 0 && m_wcnt[mch] < 65535) m_wcnt[mch]++;
      end
      if (bus.valid_i && m_ready) begin
        if (bus.select == 2'd3) begin
          nerr = 1'b1;
          if (m_drop < 65535) m_drop++;
        end else begin
          mch = int'(bus.select);
          w   = bus.data_i;
          for (int k = 3; k >= 0; k--) mq.push_back(8'((w >> (8 * k)) & 32'hFF));
        end
      end
    end else begin
      model_reset();
    end
    @(posedge clk_sys);
    #1;
    if (rst_n) begin
      exp_v   = nv;
      exp_d   = nd;
      exp_err = nerr;
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [31:0] d, input logic [2:0] b);
    bus.valid_i   = v;
    bus.select    = s;
    bus.data_i    = d;
    bus.ch_busy_i = b;
  endtask

  logic [7:0] b1 [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
  logic [7:0] b2 [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
  logic [7:0] b3 [6] = '{8'hDE, 8'h00, 8'h00, 8'hAD, 8'hBE, 8'hEF};
  logic [5:0] v3 = 6'b111001;

  initial begin
    drive(1'b0, 2'd0, 32'h0, 3'b000);
    #1;
    chk("rst_idle", 32'(bus.idle_o), 32'd1);
    chk("rst_valid", 32'({bus.valid2_o, bus.valid1_o, bus.valid0_o}), 32'd0);
    chk("rst_err", 32'(bus.err_sel_o), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Single word to channel 0.
    drive(1'b1, 2'd0, 32'hA1B2C3D4, 3'b000);
    tick();
    drive(1'b0, 2'd1, 32'h0, 3'b000);
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t1_valid", 32'(o_v), 32'd1);
      chk("t1_byte", 32'(o_d[0]), 32'(b1[k]));
    end
    tick();
    chk("t1_idle", 32'(o_idle), 32'd1);

    // Back-to-back words on channels 1 then 2.
    for (int c = 0; c < 10; c++) begin
      if (c == 0) drive(1'b1, 2'd1, 32'h11223344, 3'b000);
      else if (c <= 4) drive(1'b1, 2'd2, 32'h55667788, 3'b000);
      else drive(1'b0, 2'd0, 32'h0, 3'b000);
      tick();
      if (c < 8) chk("t2_ready", 32'(o_rdy), 32'((c == 0) || (c == 4)));
      if (c >= 2 && c <= 5) begin
        chk("t2_v1", 32'(o_v), 32'b010);
        chk("t2_d1", 32'(o_d[1]), 32'(b2[c-2]));
      end else if (c >= 6) begin
        chk("t2_v2", 32'(o_v), 32'b100);
        chk("t2_d2", 32'(o_d[2]), 32'(b2[c-2]));
      end
    end
    tick();

    // Busy stall on channel 2; channel 0 busy toggles and must not matter.
    for (int c = 0; c < 9; c++) begin
      drive(c == 0, 2'd2, 32'hDEADBEEF, {(c == 2) || (c == 3), 1'b0, c[0]});
      tick();
      if (c >= 2 && c <= 7) begin
        chk("t3_v2", 32'(o_v[2]), 32'(v3[c-2]));
        chk("t3_d2", 32'(o_d[2]), 32'(b3[c-2]));
      end
    end
    drive(1'b0, 2'd0, 32'h0, 3'b000);
    tick();

    // Invalid select is dropped.
    drive(1'b1, 2'd3, 32'hFFFFFFFF, 3'b000);
    tick();
    drive(1'b0, 2'd0, 32'h0, 3'b000);
    tick();
    chk("t4_err", 32'(o_err), 32'd1);
    chk("t4_ready", 32'(o_rdy), 32'd1);
    chk("t4_valid", 32'(o_v), 32'd0);
`ifdef DEMUX_DISPATCH_STATS_EN
    chk("t4_drop", 32'(bus.drop_cnt_o), 32'd1);
`endif
    tick();
    chk("t4_err_end", 32'(o_err), 32'd0);

    // Reset while a word is in flight.
    drive(1'b1, 2'd0, 32'hCAFEF00D, 3'b000);
    tick();
    drive(1'b0, 2'd0, 32'h0, 3'b000);
    tick();
    tick();
    tick();
    chk("t5_byte2", 32'(o_d[0]), 32'hFE);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_v", 32'(bus.valid0_o), 32'd0);
    chk("t5_async_d", 32'(bus.data0_o), 32'd0);
    chk("t5_async_idle", 32'(bus.idle_o), 32'd1);
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("t5_residual", 32'(o_v), 32'd0);
      chk("t5_idle", 32'(o_idle), 32'd1);
    end

    // Three words to channel 1.
    for (int c = 0; c < 15; c++) begin
      if (c == 0 || c == 4 || c == 8) drive(1'b1, 2'd1, 32'h01020304 + 32'(c), 3'b000);
      else drive(1'b0, 2'd0, 32'h0, 3'b000);
      tick();
    end
`ifdef DEMUX_DISPATCH_STATS_EN
    chk("t6_wc0", 32'(bus.word_cnt0_o), 32'd0);
    chk("t6_wc1", 32'(bus.word_cnt1_o), 32'd3);
    chk("t6_wc2", 32'(bus.word_cnt2_o), 32'd0);
`endif
    chk("t6_idle", 32'(o_idle), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
